// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
// Imported by mem_arbiter and rr_pick2.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam int WORD = 32;
  localparam int STRB = 4;

  function automatic logic in_window(
    input logic [WORD-1:0] addr,
    input logic [WORD-1:0] base,
    input int              abits
  );
    return (addr >> (abits + 2)) == (base >> (abits + 2));
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector.
// A tie goes to the master that did not win last time.
import mem_arb_pkg::*;

module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       pick
);

  always_comb begin
    pick = last;
    unique case (1'b1)
      (valid == 2'b11): pick = ~last;
      (valid == 2'b01): pick = 1'b0;
      (valid == 2'b10): pick = 1'b1;
      default:          pick = last;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory
// between two picorv32-native masters.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int          ADDR_BITS = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 m0_valid,
  input  logic [WORD-1:0]      m0_addr,
  input  logic [WORD-1:0]      m0_wdata,
  input  logic [STRB-1:0]      m0_wstrb,
  output logic                 m0_ready,
  output logic [WORD-1:0]      m0_rdata,
  input  logic                 m1_valid,
  input  logic [WORD-1:0]      m1_addr,
  input  logic [WORD-1:0]      m1_wdata,
  input  logic [STRB-1:0]      m1_wstrb,
  output logic                 m1_ready,
  output logic [WORD-1:0]      m1_rdata,
  output logic                 mem_en,
  output logic [STRB-1:0]      mem_wstrb,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD-1:0]      mem_wdata,
  input  logic [WORD-1:0]      mem_rdata,
  output logic                 addr_err,
  output logic                 grant
);

  state_t          state;
  logic [2:0]      cnt;
  logic            wr;
  logic            err;
  logic            pick;
  logic [WORD-1:0] sel_addr;
  logic [WORD-1:0] sel_wdata;
  logic [STRB-1:0] sel_wstrb;
  logic            sel_ok;

  rr_pick2 u_pick (
    .valid ({m1_valid, m0_valid}),
    .last  (grant),
    .pick  (pick)
  );

  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;
  assign sel_wstrb = pick ? m1_wstrb : m0_wstrb;
  assign sel_ok    = in_window(sel_addr, BASE_ADDR, ADDR_BITS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      grant     <= 1'b1;
      cnt       <= '0;
      wr        <= 1'b0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            grant <= pick;
            wr    <= |sel_wstrb;
            err   <= ~sel_ok;
            if (sel_ok) begin
              state     <= ACCESS;
              mem_en    <= 1'b1;
              mem_addr  <= sel_addr[ADDR_BITS+1:2];
              mem_wdata <= sel_wdata;
              mem_wstrb <= sel_wstrb;
            end else begin
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          if (MEM_LAT == 1) begin
            state <= RESP;
          end else begin
            state <= WAIT;
            cnt   <= 3'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          err   <= 1'b0;
        end
      endcase
    end
  end

  // Read data flows straight from memory during RESP.
  assign m0_ready = (state == RESP) && !grant;
  assign m1_ready = (state == RESP) && grant;
  assign addr_err = (state == RESP) && err;
  assign m0_rdata = (m0_ready && !wr && !err) ? mem_rdata : '0;
  assign m1_rdata = (m1_ready && !wr && !err) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases plus random
// traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int          AB   = 12;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int          LAT  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic        mv[2];
  logic [31:0] ma[2];
  logic [31:0] md[2];
  logic [3:0]  ms[2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en;
  logic [3:0]  mem_wstrb;
  logic [AB-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        addr_err, grant;

  logic        nv[2];
  logic [31:0] na[2];
  logic [31:0] nd[2];
  logic [3:0]  ns[2];
  logic        r3[2];
  logic [31:0] d3[2];
  logic        mem3_en;
  logic [3:0]  mem3_wstrb;
  logic [AB-1:0] mem3_addr;
  logic [31:0] mem3_wdata, mem3_rdata;
  logic        err3, grant3;

  mem_arbiter #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .MEM_LAT(LAT)) u0 (
    .clk(clk), .resetn(resetn),
    .m0_valid(mv[0]), .m0_addr(ma[0]), .m0_wdata(md[0]), .m0_wstrb(ms[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(mv[1]), .m1_addr(ma[1]), .m1_wdata(md[1]), .m1_wstrb(ms[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .addr_err(addr_err), .grant(grant)
  );

  mem_arbiter #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .MEM_LAT(3)) u3 (
    .clk(clk), .resetn(resetn),
    .m0_valid(nv[0]), .m0_addr(na[0]), .m0_wdata(nd[0]), .m0_wstrb(ns[0]),
    .m0_ready(r3[0]), .m0_rdata(d3[0]),
    .m1_valid(nv[1]), .m1_addr(na[1]), .m1_wdata(nd[1]), .m1_wstrb(ns[1]),
    .m1_ready(r3[1]), .m1_rdata(d3[1]),
    .mem_en(mem3_en), .mem_wstrb(mem3_wstrb), .mem_addr(mem3_addr),
    .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata),
    .addr_err(err3), .grant(grant3)
  );

  function automatic logic [31:0] pat(input int i);
    return (i == 5) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i));
  endfunction

  // Synchronous memories: latency 1 for u0, latency 3 for u3.
  logic [31:0] ram0 [0:4095];
  logic [31:0] ram3 [0:4095];
  logic [31:0] p3 [3];
  bit ram_init = 1'b0;
  assign mem3_rdata = p3[2];

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) begin
        ram0[i] <= pat(i);
        ram3[i] <= pat(i);
      end
      ram_init <= 1'b1;
    end else begin
      if (mem_en) begin
        if (mem_wstrb == 4'd0) mem_rdata <= ram0[mem_addr];
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ram0[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (mem3_en) begin
        if (mem3_wstrb == 4'd0) p3[0] <= ram3[mem3_addr];
        for (int b = 0; b < 4; b++)
          if (mem3_wstrb[b]) ram3[mem3_addr][8*b +: 8] <= mem3_wdata[8*b +: 8];
      end
    end
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state: shadow memory and last winner.
  logic [31:0] refm [0:4095];
  int          last_g;
  logic [31:0] last_rd;

  function automatic bit win(input logic [31:0] a);
    return (a / (32'd1 << (AB + 2))) == (BASE / (32'd1 << (AB + 2)));
  endfunction

  task automatic txn(
    input logic [1:0]  v,
    input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
    input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1,
    input bit          drop
  );
    int order[$];
    int s, c, m, exp_c, w;
    bit iw, done;
    logic [31:0] exp_rd;
    ma[0] = a0; md[0] = d0; ms[0] = s0;
    ma[1] = a1; md[1] = d1; ms[1] = s1;
    mv[0] = v[0]; mv[1] = v[1];
    if (v == 2'b11) begin
      order.push_back(last_g == 1 ? 0 : 1);
      order.push_back(last_g == 1 ? 1 : 0);
    end else begin
      order.push_back(v[0] ? 0 : 1);
    end
    s = 0;
    c = 0;
    foreach (order[k]) begin
      m = order[k];
      iw = win(ma[m]);
      w = int'(ma[m][AB+1:2]);
      exp_c = s + (iw ? LAT + 1 : 1);
      exp_rd = (iw && ms[m] == 4'd0) ? refm[w] : 32'd0;
      done = 1'b0;
      while (!done && c < s + 20) begin
        @(posedge clk); #1;
        c++;
        if (drop && c == 1) mv[m] = 1'b0;
        chk("mem_en", 32'(mem_en), 32'(iw && c == s + 1));
        if (iw && c == s + 1) begin
          chk("mem_addr", 32'(mem_addr), 32'(w));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(ms[m]));
          chk("mem_wdata", mem_wdata, md[m]);
        end
        if (m0_ready || m1_ready) begin
          done = 1'b1;
          chk("rdy_cycle", 32'(c), 32'(exp_c));
          chk("rdy_who", {30'd0, m1_ready, m0_ready}, (m == 0) ? 32'd1 : 32'd2);
          chk("grant", 32'(grant), 32'(m));
          chk("addr_err", 32'(addr_err), 32'(!iw));
          chk("rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rd);
          chk("rdata_other", (m == 0) ? m1_rdata : m0_rdata, 32'd0);
          last_rd = (m == 0) ? m0_rdata : m1_rdata;
          mv[m] = 1'b0;
          last_g = m;
          if (iw)
            for (int b = 0; b < 4; b++)
              if (ms[m][b]) refm[w][8*b +: 8] = md[m][8*b +: 8];
        end
      end
      chk("no_timeout", 32'(done), 32'd1);
      if (!done) mv[m] = 1'b0;
      s = c + 1;
    end
    @(posedge clk); #1;
    chk("idle_rdy", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("idle_en", 32'(mem_en), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rv;
    logic [31:0] ra[2], rd[2];
    logic [3:0]  rs[2];
    for (int i = 0; i < 4096; i++) refm[i] = pat(i);
    last_g = 1;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = '0; md[i] = '0; ms[i] = '0;
      nv[i] = 1'b0; na[i] = '0; nd[i] = '0; ns[i] = '0;
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdy", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_rdata1", m1_rdata, 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    txn(2'b01, BASE + 32'h14, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("read_w5", last_rd, 32'hDEAD_BEEF);
    txn(2'b10, 32'd0, 32'd0, 4'd0, BASE + 32'h8, 32'h1234_5678, 4'b0011, 1'b0);
    txn(2'b01, BASE + 32'h8, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("readback_w2", last_rd, 32'hA5A5_5678);
    txn(2'b01, 32'h0000_0100, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    txn(2'b01, BASE + 32'h14, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    chk("drop_valid", last_rd, 32'hDEAD_BEEF);

    // Latency-3 instance: mem_en in cycle 1, ready in cycle 4.
    nv[0] = 1'b1; na[0] = BASE + 32'h1C;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk("l3_en", 32'(mem3_en), 32'(c == 1));
      if (c == 1) chk("l3_addr", 32'(mem3_addr), 32'd7);
      chk("l3_rdy", 32'(r3[0]), 32'(c == 4));
      if (c == 4) chk("l3_rdata", d3[0], 32'hA5A5_0007);
    end
    nv[0] = 1'b0;
    @(posedge clk); #1;

    // Reset while u3 sits in its wait state.
    nv[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_en", 32'(mem3_en), 32'd0);
    chk("mid_wstrb", 32'(mem3_wstrb), 32'd0);
    chk("mid_addr", 32'(mem3_addr), 32'd0);
    chk("mid_wdata", mem3_wdata, 32'd0);
    chk("mid_rdy", {30'd0, r3[1], r3[0]}, 32'd0);
    chk("mid_rdata", d3[0] | d3[1], 32'd0);
    chk("mid_err", 32'(err3), 32'd0);
    chk("mid_grant", 32'(grant3), 32'd1);
    nv[0] = 1'b0;
    last_g = 1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("post_rst_rdy", {30'd0, r3[1], r3[0]}, 32'd0);
    end
    nv[0] = 1'b1; na[0] = BASE + 32'h4;
    nv[1] = 1'b1; na[1] = BASE + 32'h8;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      chk("l3_tie", {30'd0, r3[1], r3[0]},
          (c == 4) ? 32'd1 : (c == 9) ? 32'd2 : 32'd0);
      if (c == 4) begin
        chk("l3_tie_rd0", d3[0], 32'hA5A5_0001);
        nv[0] = 1'b0;
      end
      if (c == 9) begin
        chk("l3_tie_rd1", d3[1], 32'hA5A5_0002);
        nv[1] = 1'b0;
      end
    end

    // Dual traffic right after reset: m0 first, then alternation.
    for (int i = 0; i < 3; i++)
      txn(2'b11, BASE + 32'h10, 32'd0, 4'd0, BASE + 32'h20, 32'd0, 4'd0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      rv = 2'($urandom_range(1, 3));
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 4) != 0)
          ra[j] = BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
        else
          ra[j] = $urandom;
        rd[j] = $urandom;
        rs[j] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      end
      txn(rv, ra[0], rd[0], rs[0], ra[1], rd[1], rs[1], 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("gap_en", 32'(mem_en), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
